// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: WIDTH-bit flip-flop register shared by two requesters under
// a round-robin arbiter. Each granted cycle performs one read (the old value)
// and, optionally, a write.
// Optional build macro: ARB_LOCK_EN lets the granted port keep the grant for up
// to MAX_LOCK consecutive cycles by holding lockx together with reqx.
module dff_reg_arbiter #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       MAX_LOCK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             lock0,
    input  logic             lock1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             last_q, last_d;

    // Lock holds: the granted port keeps the grant while locking, unless its
    // run has expired and the other port is waiting.
    logic             hold0_c;
    logic             hold1_c;

`ifdef ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_LOCK) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_expired_c;

    assign lock_expired_c = (cnt_q >= CNT_W'(MAX_LOCK - 1));
    assign hold0_c        = req0 & lock0 & ~(lock_expired_c & req1);
    assign hold1_c        = req1 & lock1 & ~(lock_expired_c & req0);

    // Count consecutive cycles in the same grant state; restart on expiry.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && (state_q != IDLE)) begin
            cnt_d = lock_expired_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Lock run counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_lock;

    assign hold0_c     = 1'b0;
    assign hold1_c     = 1'b0;
    assign unused_lock = ^{lock0, lock1, 32'(MAX_LOCK)};
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_q       <= RESET_VAL;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            last_q    <= last_d;
        end
    end

    // Next-state: round-robin on ties, the other port preferred after a grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (hold0_c) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                if (hold1_c) begin
                    state_d = GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Access: read old value, optional write, only if the grantee still requests.
    always_comb begin
        q_d       = q_q;
        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        last_d    = last_q;
        if ((state_q == GRANT0) && req0) begin
            rdata_d   = q_q;
            rvalid0_d = 1'b1;
            last_d    = 1'b0;
            if (we0) begin
                q_d = wdata0;
            end
        end else if ((state_q == GRANT1) && req1) begin
            rdata_d   = q_q;
            rvalid1_d = 1'b1;
            last_d    = 1'b1;
            if (we1) begin
                q_d = wdata1;
            end
        end
    end

    assign gnt0    = (state_q == GRANT0);
    assign gnt1    = (state_q == GRANT1);
    assign busy    = (state_q != IDLE);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;
    assign q       = q_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_dff_reg_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam logic [7:0]  RESET_VAL = 8'h00;
    localparam int          MAX_LOCK  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [WIDTH-1:0] rdata, q;

    int n_checks = 0;
    int n_fail   = 0;

    dff_reg_arbiter #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .lock0  (lock0),
        .lock1  (lock1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata  (rdata),
        .q      (q),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: which port holds the grant this cycle (-1 none); run: how many
    // consecutive cycles it has held it.
    int         m_own;
    int         m_run;
    int         m_last;
    logic [7:0] m_q;
    logic [7:0] m_rdata;
    logic       m_rv [2];
    bit         m_ok = 1'b0;

    always @(posedge clk) begin
        logic       rq [2];
        logic       we [2];
        logic       lk [2];
        logic [7:0] wd [2];
        int         nxt;
        int         oth;
        rq[0] = req0;   rq[1] = req1;
        we[0] = we0;    we[1] = we1;
        lk[0] = lock0;  lk[1] = lock1;
        wd[0] = wdata0; wd[1] = wdata1;
        if (!rst_n) begin
            m_own   = -1;
            m_run   = 0;
            m_last  = 1;
            m_q     = RESET_VAL;
            m_rdata = 8'h00;
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            if (m_own < 0) begin
                if (rq[0] && rq[1]) nxt = 1 - m_last;
                else if (rq[0])     nxt = 0;
                else if (rq[1])     nxt = 1;
                else                nxt = -1;
            end else begin
                oth = 1 - m_own;
                if (rq[m_own]) begin
                    m_rdata     = m_q;
                    m_rv[m_own] = 1'b1;
                    if (we[m_own]) m_q = wd[m_own];
                    m_last = m_own;
                end
`ifdef ARB_LOCK_EN
                if (rq[m_own] && lk[m_own] && !(m_run >= MAX_LOCK && rq[oth]))
                    nxt = m_own;
                else
`endif
                if (rq[oth])        nxt = oth;
                else if (rq[m_own]) nxt = m_own;
                else                nxt = -1;
            end
            if (nxt < 0)             m_run = 0;
            else if (nxt != m_own)   m_run = 1;
            else                     m_run = (m_run >= MAX_LOCK) ? 1 : m_run + 1;
            m_own = nxt;
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_gnt0",    32'(gnt0),    32'(m_own == 0));
            chk("m_gnt1",    32'(gnt1),    32'(m_own == 1));
            chk("m_busy",    32'(busy),    32'(m_own >= 0));
            chk("m_rvalid0", 32'(rvalid0), 32'(m_rv[0]));
            chk("m_rvalid1", 32'(rvalid1), 32'(m_rv[1]));
            chk("m_q",       32'(q),       32'(m_q));
            if (m_rv[0] || m_rv[1]) chk("m_rdata", 32'(rdata), 32'(m_rdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; wdata0 = 8'h00; wdata1 = 8'h00;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        req0  = 1'b1;

        // Reset held two cycles while port 0 requests.
        cyc(); cyc();
        chk("rst_q",     32'(q), 32'h00);
        chk("rst_gnt0",  32'(gnt0), 32'd0);
        chk("rst_gnt1",  32'(gnt1), 32'd0);
        chk("rst_rv",    32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);

        // Single write then read on port 0.
        rst_n = 1'b1; we0 = 1'b1; wdata0 = 8'hA5;
        cyc();
        chk("wr_gnt0", 32'(gnt0), 32'd1);
        chk("wr_q_pre", 32'(q), 32'h00);
        cyc();
        chk("wr_rvalid0", 32'(rvalid0), 32'd1);
        chk("wr_rdata_old", 32'(rdata), 32'h00);
        chk("wr_q_new", 32'(q), 32'hA5);
        we0 = 1'b0;
        cyc();
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        req0 = 1'b0;
        cyc();
        chk("rd_cancel_rv0", 32'(rvalid0), 32'd0);
        chk("rd_idle_busy", 32'(busy), 32'd0);

        // Tie right after reset: port 0 wins, then port 1 writes.
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; we1 = 1'b1; wdata1 = 8'h3C;
        cyc();
        chk("tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cyc();
        chk("tie_gnt1", 32'({gnt0, gnt1}), 32'b01);
        chk("tie_rv0_rdata", 32'(rdata), 32'h00);
        req0 = 1'b0;
        cyc();
        chk("tie_rv1", 32'(rvalid1), 32'd1);
        chk("tie_rv1_rdata", 32'(rdata), 32'h00);
        chk("tie_q", 32'(q), 32'h3C);
        req1 = 1'b0; we1 = 1'b0;
        cyc();
        chk("tie_idle", 32'(busy), 32'd0);

        // Continuous contention: strict alternation starting at port 0.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("alt_gnt", 32'({gnt0, gnt1}), (i % 2 == 0) ? 32'b10 : 32'b01);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();

        // One-cycle pulse on port 1: grant issued, access cancelled.
        req1 = 1'b1;
        cyc();
        chk("cancel_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        cyc();
        chk("cancel_rv1", 32'(rvalid1), 32'd0);
        chk("cancel_q", 32'(q), 32'h3C);

        // Reset during a grant cycle with a pending write.
        req0 = 1'b1; we0 = 1'b1; wdata0 = 8'hFF;
        cyc();
        chk("midrst_gnt0", 32'(gnt0), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_q", 32'(q), 32'h00);
        chk("midrst_rv0", 32'(rvalid0), 32'd0);
        chk("midrst_gnt0_off", 32'(gnt0), 32'd0);
        rst_n = 1'b1; idle_inputs();
        cyc();

        // Port 0 locking against a continuously requesting port 1.
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
        cyc();
`ifdef ARB_LOCK_EN
        for (int k = 0; k < MAX_LOCK; k++) begin
            chk("lock_hold_gnt0", 32'({gnt0, gnt1}), 32'b10);
            cyc();
        end
        chk("lock_force_gnt1", 32'({gnt0, gnt1}), 32'b01);
`else
        chk("nolock_gnt0", 32'({gnt0, gnt1}), 32'b10);
        cyc();
        chk("nolock_gnt1", 32'({gnt0, gnt1}), 32'b01);
        cyc();
        chk("nolock_gnt0b", 32'({gnt0, gnt1}), 32'b10);
`endif
        idle_inputs();
        cyc();

        // Randomized traffic, checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            lock0  = ($urandom_range(0, 2) == 0);
            lock1  = ($urandom_range(0, 2) == 0);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            cyc();
        end
        idle_inputs();
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
